// File: rtl/jpeg_pkg.sv
// Shared definitions for the JPEG host port: sequencer state encoding and default sizes.
package jpeg_pkg;

   localparam int unsigned PIX_COUNT_DEF = 1024;
   localparam int unsigned CPU_BUS       = 32;
   localparam int unsigned PTR_W         = 17;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StWaitRdy,
      StIssue,
      StLatch,
      StHold,
      StDone
   } jpeg_state_e;

endpackage

// File: rtl/jpeg_host_rdport.sv
// Readback engine: walks the word pointer, waits out the core's read latency and holds
// each result word on the ready/valid output until it is taken.
module jpeg_host_rdport #(
   parameter int unsigned BUS_W    = 32,
   parameter int unsigned PTR_W    = 17,
   parameter int unsigned READ_LAT = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             issue,
   input  logic             latch,
   input  logic             hold,
   input  logic [PTR_W-1:0] words,
   input  logic [BUS_W-1:0] cpu_out,
   input  logic             res_ready,
   output logic [PTR_W-1:0] ptr_out,
   output logic             res_valid,
   output logic [BUS_W-1:0] res_data,
   output logic             lat_zero,
   output logic             last_word
);

   localparam int unsigned LatW = 2;

   logic [PTR_W-1:0] ptr_q;
   logic [LatW-1:0]  lat_q;
   logic             res_valid_q;
   logic [BUS_W-1:0] res_data_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ptr_q       <= '0;
         lat_q       <= '0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
      end else if (clear) begin
         ptr_q       <= '0;
         lat_q       <= '0;
         res_valid_q <= 1'b0;
      end else if (issue) begin
         lat_q <= LatW'(READ_LAT - 1);
      end else if (latch) begin
         if (lat_q == '0) begin
            res_data_q  <= cpu_out;
            res_valid_q <= 1'b1;
         end else begin
            lat_q <= lat_q - LatW'(1);
         end
      end else if (hold && res_ready) begin
         res_valid_q <= 1'b0;
         ptr_q       <= ptr_q + PTR_W'(1);
      end
   end

   assign ptr_out   = ptr_q;
   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;
   assign lat_zero  = (lat_q == '0);
   // Only meaningful while words is nonzero; a zero count never reaches readback.
   assign last_word = (ptr_q == (words - PTR_W'(1)));

endmodule

// File: rtl/jpeg_host_port.sv
// Host-side initiator for the JPEG core CPU bus: loads one frame of pixels, waits for
// out_ready, then streams the programmed number of encoded words back out.
module jpeg_host_port #(
   parameter int unsigned PIX_COUNT = jpeg_pkg::PIX_COUNT_DEF,
   parameter int unsigned BUS_W     = jpeg_pkg::CPU_BUS,
   parameter int unsigned PTR_W     = jpeg_pkg::PTR_W,
   parameter int unsigned READ_LAT  = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [PTR_W-1:0] out_words,
   input  logic             src_valid,
   input  logic [23:0]      src_data,
   output logic             src_ready,
   output logic             enable,
   output logic             write,
   output logic [BUS_W-1:0] cpu_in,
   input  logic             out_ready,
   output logic [PTR_W-1:0] ptr_out,
   input  logic [BUS_W-1:0] cpu_out,
   output logic             res_valid,
   output logic [BUS_W-1:0] res_data,
   input  logic             res_ready,
   output logic             busy,
   output logic             done
);

   import jpeg_pkg::*;

   localparam int unsigned CntW = $clog2(PIX_COUNT + 1);

   jpeg_state_e      state_q, state_d;
   logic [PTR_W-1:0] words_q;
   logic [CntW-1:0]  pix_cnt_q;
   logic [BUS_W-1:0] cpu_in_q;
   logic             frame_go;
   logic             xfer;
   logic             last_pix;
   logic             lat_zero;
   logic             last_word;

   assign frame_go  = (state_q == StIdle) && start;
   assign src_ready = (state_q == StLoad);
   assign xfer      = src_ready && src_valid;
   assign last_pix  = (pix_cnt_q == CntW'(PIX_COUNT - 1));
   assign write     = xfer;
   // Bus shows the live pixel on a transfer, otherwise keeps the last written one.
   assign cpu_in    = xfer ? BUS_W'(src_data) : cpu_in_q;
   assign busy      = (state_q != StIdle);
   assign done      = (state_q == StDone);
   assign enable    = busy && !done;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:    if (start) state_d = StLoad;
         StLoad:    if (xfer && last_pix) state_d = StWaitRdy;
         StWaitRdy: begin
            if (words_q == '0) begin
               state_d = StDone;
            end else if (out_ready) begin
               state_d = StIssue;
            end
         end
         StIssue:   state_d = StLatch;
         StLatch:   if (lat_zero) state_d = StHold;
         StHold:    if (res_ready) state_d = last_word ? StDone : StIssue;
         StDone:    state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         words_q   <= '0;
         pix_cnt_q <= '0;
         cpu_in_q  <= '0;
      end else begin
         state_q <= state_d;
         if (frame_go) begin
            words_q   <= out_words;
            pix_cnt_q <= '0;
         end else if (xfer) begin
            pix_cnt_q <= pix_cnt_q + CntW'(1);
         end
         if (xfer) cpu_in_q <= BUS_W'(src_data);
      end
   end

   jpeg_host_rdport #(
      .BUS_W    (BUS_W),
      .PTR_W    (PTR_W),
      .READ_LAT (READ_LAT)
   ) u_rdport (
      .clock     (clock),
      .reset     (reset),
      .clear     (frame_go),
      .issue     (state_q == StIssue),
      .latch     (state_q == StLatch),
      .hold      (state_q == StHold),
      .words     (words_q),
      .cpu_out   (cpu_out),
      .res_ready (res_ready),
      .ptr_out   (ptr_out),
      .res_valid (res_valid),
      .res_data  (res_data),
      .lat_zero  (lat_zero),
      .last_word (last_word)
   );

endmodule

// File: tb/tb_jpeg_host_port.sv
// Randomized bench for jpeg_host_port against a pixel-sequence and word-memory reference.
module tb_jpeg_host_port;

   localparam int unsigned PIX = 1024;
   localparam int unsigned BW  = 32;
   localparam int unsigned PW  = 17;

   logic          clock = 1'b0;
   logic          reset, start, src_valid, out_ready, res_ready;
   logic [PW-1:0] out_words, ptr_out;
   logic [23:0]   src_data;
   logic          src_ready, enable, write, res_valid, busy, done;
   logic [BW-1:0] cpu_in, cpu_out, res_data;

   int            n_cmp  = 0;
   int            n_fail = 0;
   logic [23:0]   pix [PIX];
   logic [BW-1:0] last_in;
   bit            aborted;

   always #5 clock = ~clock;

   // Core model: cpu_out follows ptr_out one cycle later, mem[i] = 0xA5000000 + i.
   always @(posedge clock) cpu_out <= 32'hA500_0000 + 32'(ptr_out);

   jpeg_host_port #(
      .PIX_COUNT (PIX),
      .BUS_W     (BW),
      .PTR_W     (PW),
      .READ_LAT  (1)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .out_words (out_words),
      .src_valid (src_valid),
      .src_data  (src_data),
      .src_ready (src_ready),
      .enable    (enable),
      .write     (write),
      .cpu_in    (cpu_in),
      .out_ready (out_ready),
      .ptr_out   (ptr_out),
      .cpu_out   (cpu_out),
      .res_valid (res_valid),
      .res_data  (res_data),
      .res_ready (res_ready),
      .busy      (busy),
      .done      (done)
   );

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; src_valid = 1'b0; src_data = '0;
      out_ready = 1'b0; res_ready = 1'b0; out_words = '0;
      repeat (2) @(posedge clock);
      #1;
      n_cmp++;
      if ({src_ready, enable, write, res_valid, busy, done} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_flags got=%b exp=000000",
                  {src_ready, enable, write, res_valid, busy, done});
      end
      n_cmp++;
      if (cpu_in !== '0 || ptr_out !== '0 || res_data !== '0) begin
         n_fail++;
         $display("FAIL reset_buses cpu_in=%h ptr_out=%h res_data=%h exp=0", cpu_in, ptr_out,
                  res_data);
      end
      reset = 1'b0;
      @(posedge clock);
      #1;
      n_cmp++;
      if (busy !== 1'b0 || src_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_after_reset busy=%b src_ready=%b exp=0", busy, src_ready);
      end
      last_in = '0;
   endtask

   task automatic start_frame(input int words);
      @(posedge clock);
      #1;
      n_cmp++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_before_start busy=%b exp=0", busy);
      end
      start = 1'b1;
      out_words = PW'(words);
      src_valid = 1'b0;
   endtask

   // mode 0: gapless 1..PIX; mode 1: valid every other cycle; mode 2: random valid + stray starts.
   task automatic load_frame(input int mode, input int abort_at, output bit ab);
      int acc    = 0;
      int writes = 0;
      bit fin    = 0;
      bit post   = 0;
      bit exp_rdy, exp_wr;
      logic [BW-1:0] exp_in;
      ab = 0;
      for (int i = 0; i < PIX; i++) pix[i] = (mode == 0) ? 24'(i + 1) : 24'($urandom);
      for (int cyc = 0; cyc < 6000 && !fin; cyc++) begin
         @(posedge clock);
         #1;
         start = 1'b0;
         if (post) src_valid = 1'b1;
         else if (mode == 0) src_valid = 1'b1;
         else if (mode == 1) src_valid = 1'(cyc % 2);
         else src_valid = ($urandom_range(0, 3) != 0);
         if (mode == 2) begin
            start = ($urandom_range(0, 15) == 0);
            out_words = PW'($urandom_range(4, 9));
         end
         src_data = (acc < int'(PIX)) ? pix[acc] : 24'($urandom);
         #1;
         exp_rdy = (acc < int'(PIX));
         exp_wr  = src_valid && exp_rdy;
         exp_in  = exp_wr ? {8'h00, src_data} : last_in;
         n_cmp++;
         if (src_ready !== exp_rdy) begin
            n_fail++;
            if (n_fail <= 20) $display("FAIL src_ready pix=%0d got=%b exp=%b", acc, src_ready,
                                       exp_rdy);
         end
         n_cmp++;
         if (write !== exp_wr) begin
            n_fail++;
            if (n_fail <= 20) $display("FAIL write pix=%0d got=%b exp=%b", acc, write, exp_wr);
         end
         n_cmp++;
         if (cpu_in !== exp_in) begin
            n_fail++;
            if (n_fail <= 20) $display("FAIL cpu_in pix=%0d got=%h exp=%h", acc, cpu_in, exp_in);
         end
         n_cmp++;
         if (busy !== 1'b1 || enable !== 1'b1) begin
            n_fail++;
            if (n_fail <= 20) $display("FAIL load_active busy=%b enable=%b exp=1", busy, enable);
         end
         if (write === 1'b1) writes++;
         if (exp_wr) begin
            last_in = {8'h00, src_data};
            acc++;
         end
         if (post) fin = 1;
         else if (acc == int'(PIX)) post = 1;
         if (abort_at > 0 && acc == abort_at) begin
            #2 reset = 1'b1;
            #1;
            n_cmp++;
            if ({src_ready, enable, write, res_valid, busy, done} !== 6'b0) begin
               n_fail++;
               $display("FAIL abort_flags got=%b exp=000000",
                        {src_ready, enable, write, res_valid, busy, done});
            end
            n_cmp++;
            if (cpu_in !== '0 || ptr_out !== '0 || res_data !== '0) begin
               n_fail++;
               $display("FAIL abort_buses cpu_in=%h ptr_out=%h res_data=%h exp=0", cpu_in,
                        ptr_out, res_data);
            end
            start = 1'b0;
            src_valid = 1'b0;
            @(posedge clock);
            #1 reset = 1'b0;
            last_in = '0;
            ab = 1;
            return;
         end
      end
      n_cmp++;
      if (!fin) begin
         n_fail++;
         $display("FAIL load_timeout accepted=%0d exp=%0d", acc, PIX);
      end
      n_cmp++;
      if (writes != int'(PIX)) begin
         n_fail++;
         $display("FAIL write_count got=%0d exp=%0d", writes, PIX);
      end
   endtask

   task automatic test_readback(input int words, input int wait_cyc, input int stall_k,
                                input int stall_n);
      bit            got;
      logic [BW-1:0] held;
      out_ready = 1'b0;
      res_ready = 1'b0;
      for (int c = 0; c < wait_cyc; c++) begin
         @(posedge clock);
         #1 start = 1'b0;
         #1;
         n_cmp++;
         if (ptr_out !== '0 || res_valid !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            if (n_fail <= 20) $display("FAIL wait_rdy ptr=%h valid=%b busy=%b done=%b exp=0/0/1/0",
                                       ptr_out, res_valid, busy, done);
         end
      end
      out_ready = 1'b1;
      for (int k = 0; k < words; k++) begin
         got = 0;
         for (int c = 0; c < 20 && !got; c++) begin
            @(posedge clock);
            #1 start = 1'b0;
            res_ready = 1'b0;
            #1;
            got = (res_valid === 1'b1);
         end
         if (k == 0) out_ready = 1'b0;
         n_cmp++;
         if (!got) begin
            n_fail++;
            $display("FAIL res_timeout word=%0d got=res_valid low exp=res_valid high", k);
         end
         n_cmp++;
         if (res_data !== 32'hA500_0000 + 32'(k)) begin
            n_fail++;
            $display("FAIL res_data word=%0d got=%h exp=%h", k, res_data, 32'hA500_0000 + 32'(k));
         end
         n_cmp++;
         if (ptr_out !== PW'(k)) begin
            n_fail++;
            $display("FAIL ptr_in_hold word=%0d got=%0d exp=%0d", k, ptr_out, k);
         end
         held = res_data;
         if (k == stall_k) begin
            for (int s = 0; s < stall_n; s++) begin
               @(posedge clock);
               #2;
               n_cmp++;
               if (res_valid !== 1'b1 || res_data !== held || ptr_out !== PW'(k)) begin
                  n_fail++;
                  $display("FAIL stall word=%0d valid=%b data=%h ptr=%0d exp=1/%h/%0d", k,
                           res_valid, res_data, ptr_out, held, k);
               end
            end
         end
         @(posedge clock);
         #1 res_ready = 1'b1;
         @(posedge clock);
         #1 res_ready = 1'b0;
         #1;
         n_cmp++;
         if (res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL valid_drop word=%0d got=%b exp=0", k, res_valid);
         end
         n_cmp++;
         if (ptr_out !== PW'(k + 1)) begin
            n_fail++;
            $display("FAIL ptr_advance word=%0d got=%0d exp=%0d", k, ptr_out, k + 1);
         end
         n_cmp++;
         if (done !== 1'(k == words - 1)) begin
            n_fail++;
            $display("FAIL done_pulse word=%0d got=%b exp=%b", k, done, k == words - 1);
         end
      end
      @(posedge clock);
      #2;
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0 || enable !== 1'b0) begin
         n_fail++;
         $display("FAIL back_to_idle busy=%b done=%b enable=%b exp=0", busy, done, enable);
      end
   endtask

   task automatic test_gapless();
      start_frame(3);
      load_frame(0, 0, aborted);
      test_readback(3, 50, 1, 10);
   endtask

   task automatic test_toggle_zero_words();
      start_frame(0);
      load_frame(1, 0, aborted);
      @(posedge clock);
      #2;
      n_cmp++;
      if (done !== 1'b1 || res_valid !== 1'b0 || busy !== 1'b1 || enable !== 1'b0) begin
         n_fail++;
         $display("FAIL zero_words_done done=%b valid=%b busy=%b enable=%b exp=1/0/1/0", done,
                  res_valid, busy, enable);
      end
      @(posedge clock);
      #2;
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL zero_words_idle done=%b busy=%b exp=0/0", done, busy);
      end
   endtask

   task automatic test_reset_abort();
      start_frame(2);
      load_frame(2, 500, aborted);
      n_cmp++;
      if (!aborted) begin
         n_fail++;
         $display("FAIL abort_reached got=not reached exp=reached pixel 500");
      end
      start_frame(2);
      load_frame(2, 0, aborted);
      test_readback(2, 5, 0, 3);
   endtask

   initial begin
      test_reset();
      test_gapless();
      test_toggle_zero_words();
      test_reset_abort();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/jpeg_host_port.md
Name: jpeg_host_port

Overview:
- Host-side initiator for the JPEG core's CPU bus: the other end of the enable/write/cpu_in load path and the ptr_out/cpu_out/out_ready readback path.
- Pulls one frame of packed 24-bit RGB pixels from a ready/valid source stream and writes them into the core, one pixel per write cycle.
- Waits for the core's out_ready, then reads back a programmed number of 32-bit JPEG words by pointer and emits them on a ready/valid result stream.
- Sits between the system bus/DMA and the JPEG controller top.

Parameters:
- PIX_COUNT, 1024: pixels written per frame.
- BUS_W, 32: CPU bus width (cpu_in, cpu_out, res_data).
- PTR_W, 17: readback pointer width.
- READ_LAT, 1: cycles from a ptr_out change to valid cpu_out (1..3).

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a frame; ignored unless in IDLE.
- out_words  in  PTR_W  number of JPEG words to read back; sampled on start.
- src_valid  in  1  pixel available on src_data.
- src_data  in  24  pixel, {R,G,B}.
- src_ready  out  1  pixel accepted when src_valid && src_ready.
- enable  out  1  frame-active level to the core.
- write  out  1  pixel write strobe to the core.
- cpu_in  out  BUS_W  {8'h00, pixel} to the core.
- out_ready  in  1  core's encoded output is readable.
- ptr_out  out  PTR_W  readback word address to the core.
- cpu_out  in  BUS_W  readback data from the core.
- res_valid  out  1  result word valid.
- res_data  out  BUS_W  result word.
- res_ready  in  1  downstream accepts the result word.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at the end of a frame.

Behaviour:
- Reset values: state IDLE; all outputs 0; pixel counter, pointer and latency counter 0.
- Reset mid-operation aborts the frame immediately and returns to IDLE. No done pulse is produced.
- IDLE: on start, latch out_words into words_q, clear the counters and go to LOAD.
- LOAD:
  - enable=1; src_ready=1.
  - When src_valid=1, write=1 and cpu_in={8'h00,src_data} in the same cycle (combinational from the handshake; no added latency).
  - When src_valid=0, write=0 and cpu_in holds its last value. Gaps are legal.
  - The pixel counter increments on each transfer. On the PIX_COUNT-th transfer, src_ready drops next cycle and the state goes to WAIT_RDY.
  - No pixel beyond PIX_COUNT is ever accepted.
- WAIT_RDY:
  - enable=1; write=0.
  - If words_q==0, go to DONE without waiting.
  - Otherwise wait for out_ready=1, then go to ISSUE with ptr_out=0.
- ISSUE: ptr_out holds the current pointer. Load the latency counter with READ_LAT-1, then go to LATCH.
- LATCH:
  - Count down.
  - At zero, register cpu_out into res_data, set res_valid=1 and go to HOLD.
- HOLD:
  - res_valid and res_data stay stable until res_ready=1. Backpressure is unbounded.
  - On the handshake, res_valid drops next cycle and ptr_out increments.
  - If the pointer equals words_q-1, go to DONE; otherwise go to ISSUE.
  - Only one word is in flight at a time.
- DONE: done=1 for one cycle; enable=0; go to IDLE. busy is 1 in DONE.
- out_ready falling during readback is ignored; it is only sampled in WAIT_RDY.
- ptr_out wraps modulo 2^PTR_W, which cannot happen for words_q ≤ 2^PTR_W.
- start during busy=1 has no effect.

Decomposition:
- Shared package jpeg_pkg holds:
  - state encoding (IDLE, LOAD, WAIT_RDY, ISSUE, LATCH, HOLD, DONE);
  - the constants PIX_COUNT_DEF=1024, CPU_BUS=32, PTR_W=17.
- One natural sub-module, jpeg_host_rdport: ISSUE/LATCH/HOLD readback engine with pointer and latency counter.
- The top module keeps the load FSM and sequencing.

Test Plan:
- Reset, then start with out_words=3 and a gapless source of pixels 0x000001..0x000400. Expect exactly 1024 write pulses with cpu_in=0x00000001..0x00000400, then src_ready=0.
- Source with src_valid toggling every other cycle. Expect write to mirror each handshake and the pixel count to stay 1024, with no extra writes.
- Hold out_ready=0 for 50 cycles after the load. Expect ptr_out to stay 0, res_valid=0 and busy=1. Raise out_ready with cpu_out=mem[ptr] (mem[i]=0xA5000000+i) and READ_LAT=1. Expect res_data 0xA5000000, 0xA5000001, 0xA5000002, then a done pulse.
- Hold res_ready=0 for 10 cycles on word 1. Expect res_data to stay stable and ptr_out not to advance until the handshake.
- out_words=0. Expect done right after the load, with no out_ready wait and no res_valid.
- Assert reset asynchronously at pixel 500. Expect all outputs 0 immediately. A following start reloads the full 1024 pixels.
